// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter slice.
// Holds the arbiter FSM state encoding, the default sizing constants and the
// fixed width of the grant index.
package uart_arb_pkg;

  localparam int N_REQ_DEF         = 4;
  localparam int BUSY_TIMEOUT_DEF  = 16;
  localparam int MAX_MSG_BYTES_DEF = 32;
  localparam int GRANT_W           = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker (purely combinational).
// Scans req starting at last_grant+1 with wrap-around and reports the first
// asserted index.
//   req        : request vector, one bit per source
//   last_grant : index granted most recently (lowest priority this round)
//   any        : at least one request is asserted
//   idx        : chosen index; 0 when any=0
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF
) (
  input  logic [N-1:0]       req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               any,
  output logic [GRANT_W-1:0] idx
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk the candidates in priority order; the first hit freezes idx.
  always_comb begin
    any    = 1'b0;
    idx    = {GRANT_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s = IDX_W'((int'(last_grant) + k) % N);
      hit_s  = !any && req[cand_s];
      idx    = hit_s ? GRANT_W'(cand_s) : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream message sources.
// A source keeps the grant from its first byte through its last-flagged byte
// (or until MAX_MSG_BYTES bytes), so messages never interleave on the wire.
// Grants rotate round-robin between messages.
//   clk_in, reset_in : clock; asynchronous active-high reset
//   req_valid/req_data/req_last : per-source byte offer (byte i at [8*i+7:8*i])
//   req_ready        : combinational per-source byte-accept pulse
//   tx_start/tx_data : registered one-cycle start pulse and byte to the UART
//   tx_busy          : UART busy
//   grant_valid/grant_id : message in progress and owning source
//   msg_done         : one-cycle pulse after a message releases
//   err_timeout      : sticky, tx_busy never rose after a tx_start
//   err_overlength   : sticky, a grant hit the byte cap without req_last
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int BUSY_TIMEOUT  = BUSY_TIMEOUT_DEF,
  parameter int MAX_MSG_BYTES = MAX_MSG_BYTES_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 msg_done,
  output logic                 err_timeout,
  output logic                 err_overlength
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_MSG_BYTES + 1);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MSG_BYTES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               last_q, last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               msg_done_q, msg_done_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_overlength_q, err_overlength_d;

  logic               pick_any_s;
  logic [GRANT_W-1:0] pick_idx_s;
  logic [IDX_W-1:0]   gsel_s;
  logic [7:0]         src_byte_s [N_REQ];

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any        (pick_any_s),
    .idx        (pick_idx_s)
  );

  assign gsel_s = grant_id_q[IDX_W-1:0];

  // Split the flat data bus into one byte per source.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      src_byte_s[i] = req_data[8*i +: 8];
    end
  end

  // Next-state and handshake logic of the arbiter FSM.
  always_comb begin
    state_d          = state_q;
    grant_id_d       = grant_id_q;
    grant_valid_d    = grant_valid_q;
    last_grant_d     = last_grant_q;
    byte_cnt_d       = byte_cnt_q;
    to_cnt_d         = to_cnt_q;
    last_d           = last_q;
    tx_data_d        = tx_data_q;
    tx_start_d       = 1'b0;
    msg_done_d       = 1'b0;
    err_timeout_d    = err_timeout_q;
    err_overlength_d = err_overlength_q;
    req_ready        = {N_REQ{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_id_d    = pick_idx_s;
          grant_valid_d = 1'b1;
          state_d       = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // A byte is only taken once the UART has drained, so a transfer
        // still running from before the grant is never overrun.
        if (req_valid[gsel_s] && !tx_busy) begin
          req_ready[gsel_s] = 1'b1;
          tx_data_d         = src_byte_s[gsel_s];
          tx_start_d        = 1'b1;
          last_d            = req_last[gsel_s];
          byte_cnt_d        = (byte_cnt_q == CNT_MAX) ? byte_cnt_q
                                                      : byte_cnt_q + CNT_W'(1);
          to_cnt_d          = {TO_W{1'b0}};
          state_d           = ST_WAIT_BUSY;
        end else begin
          state_d = ST_START;
        end
      end
      ST_WAIT_BUSY: begin
        // On timeout the byte counts as sent so the message can still finish.
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q >= TO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ST_WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            state_d = ST_RELEASE;
          end else if (byte_cnt_q == CNT_MAX) begin
            err_overlength_d = 1'b1;
            state_d          = ST_RELEASE;
          end else begin
            state_d = ST_START;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RELEASE: begin
        msg_done_d    = 1'b1;
        last_grant_d  = grant_id_q;
        grant_valid_d = 1'b0;
        byte_cnt_d    = {CNT_W{1'b0}};
        state_d       = ST_IDLE;
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q          <= ST_IDLE;
      grant_id_q       <= {GRANT_W{1'b0}};
      grant_valid_q    <= 1'b0;
      last_grant_q     <= GRANT_W'(N_REQ - 1);
      byte_cnt_q       <= {CNT_W{1'b0}};
      to_cnt_q         <= {TO_W{1'b0}};
      last_q           <= 1'b0;
      tx_data_q        <= 8'h00;
      tx_start_q       <= 1'b0;
      msg_done_q       <= 1'b0;
      err_timeout_q    <= 1'b0;
      err_overlength_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_id_q       <= grant_id_d;
      grant_valid_q    <= grant_valid_d;
      last_grant_q     <= last_grant_d;
      byte_cnt_q       <= byte_cnt_d;
      to_cnt_q         <= to_cnt_d;
      last_q           <= last_d;
      tx_data_q        <= tx_data_d;
      tx_start_q       <= tx_start_d;
      msg_done_q       <= msg_done_d;
      err_timeout_q    <= err_timeout_d;
      err_overlength_q <= err_overlength_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign grant_valid    = grant_valid_q;
  assign grant_id       = grant_id_q;
  assign msg_done       = msg_done_q;
  assign err_timeout    = err_timeout_q;
  assign err_overlength = err_overlength_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: message-level sources, a UART busy
// model, and a transaction-level reference model of grants and wire bytes.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int BT       = 16;
  localparam int MAXB     = 32;
  localparam int BUSY_CYC = 10;

  logic           clk_in = 1'b0;
  logic           reset_in;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_busy, grant_valid, msg_done, err_timeout, err_overlength;
  logic [7:0]     tx_data;
  logic [2:0]     grant_id;

  uart_tx_arbiter dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_valid(grant_valid), .grant_id(grant_id),
    .msg_done(msg_done), .err_timeout(err_timeout), .err_overlength(err_overlength)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // source side
  logic [7:0] sq_data [N][$];
  bit         sq_last [N][$];
  int         popped [N];
  int         stall_at [N];
  int         stall_left [N];
  logic [N-1:0] acc_mask;
  bit         busy_en;
  int         busy_left;
  int         cyc;

  // reference model
  int         m_last, m_src, m_cnt, e_idx;
  bit         m_end, m_ovl, m_ovl_sticky, lastf;
  logic [7:0] exp_wire [$];
  logic [7:0] sent_log [$];
  int         grant_log [$];
  int         n_start, n_done;
  int         n_ready [N];
  logic [N-1:0] valid_prev, own_mask;
  bit         gv_prev, start_prev, to_mode;
  int         t0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_expect(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sq_data[i].delete(); sq_last[i].delete();
      popped[i] = 0; stall_at[i] = -1; stall_left[i] = 0; n_ready[i] = 0;
    end
    m_last = N - 1; m_src = 0; m_cnt = 0; m_end = 1'b0; m_ovl = 1'b0; m_ovl_sticky = 1'b0;
    exp_wire.delete(); sent_log.delete(); grant_log.delete();
    n_start = 0; n_done = 0; valid_prev = '0; gv_prev = 1'b0; start_prev = 1'b0;
    to_mode = 1'b0; t0 = -1; busy_en = 1'b1;
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input bit l);
    sq_data[s].push_back(b);
    sq_last[s].push_back(l);
  endtask

  task automatic push_msg(input int s, input int len, input bit with_last);
    for (int i = 0; i < len; i++) push_byte(s, 8'($urandom), with_last && (i == len - 1));
  endtask

  task automatic do_reset();
    @(negedge clk_in); #3;
    reset_in = 1'b1;
    model_reset();
    @(negedge clk_in); #3;
    reset_in = 1'b0;
  endtask

  task automatic wait_done(input int n_msgs, input int cap);
    int c;
    c = 0;
    while (n_done < n_msgs && c < cap) begin
      @(negedge clk_in); #3;
      c++;
    end
    chk("msgs_done", n_done, n_msgs);
    repeat (3) @(negedge clk_in);
    #3;
  endtask

  // Source and UART driver: updates inputs on each falling edge.
  initial begin : drv
    acc_mask = '0; busy_left = 0; cyc = 0;
    forever begin
      @(negedge clk_in);
      if (reset_in) begin
        acc_mask = '0; busy_left = 0; tx_busy = 1'b0; req_valid = '0;
      end else begin
        cyc++;
        if (busy_en && tx_start) busy_left = BUSY_CYC;
        else if (busy_left > 0) busy_left--;
        tx_busy = (busy_left > 0);
        for (int i = 0; i < N; i++) begin
          if (acc_mask[i] && sq_data[i].size() > 0) begin
            void'(sq_data[i].pop_front());
            void'(sq_last[i].pop_front());
            popped[i]++;
            if (popped[i] == stall_at[i]) stall_left[i] = 20;
          end else if (stall_left[i] > 0) begin
            stall_left[i]--;
          end
          req_valid[i] = (sq_data[i].size() > 0) && (stall_left[i] == 0);
          req_data[8*i +: 8] = req_valid[i] ? sq_data[i][0] : 8'($urandom);
          req_last[i] = req_valid[i] ? sq_last[i][0] : 1'($urandom);
        end
      end
      #1 acc_mask = req_ready;
    end
  end

  // Compare process: checks DUT outputs against the model every cycle.
  initial begin : cmp
    forever begin
      @(negedge clk_in); #2;
      if (reset_in) begin
        gv_prev = 1'b0; start_prev = 1'b0; valid_prev = '0;
      end else begin
        if (grant_valid && !gv_prev) begin
          e_idx = rr_expect(valid_prev, m_last);
          chk("grant_id", grant_id, e_idx);
          m_src = e_idx; m_cnt = 0; m_end = 1'b0; m_ovl = 1'b0;
        end
        if (grant_valid) chk("grant_hold", grant_id, m_src);
        own_mask = grant_valid ? (N'(1) << m_src) : '0;
        chk("ready_scope", req_ready & ~own_mask, 0);
        if (grant_valid && req_ready[m_src]) begin
          chk("ready_needs_valid", req_valid[m_src], 1);
          chk("accept_after_end", m_end, 0);
          n_ready[m_src]++;
          if (sq_data[m_src].size() > 0) begin
            exp_wire.push_back(sq_data[m_src][0]);
            lastf = sq_last[m_src][0];
            m_cnt++;
            if (lastf || m_cnt == MAXB) begin
              m_end = 1'b1;
              m_ovl = !lastf;
            end
          end
        end
        if (tx_start) begin
          n_start++;
          sent_log.push_back(tx_data);
          chk("start_pulse", start_prev, 0);
          if (exp_wire.size() > 0) chk("tx_data", tx_data, exp_wire.pop_front());
          else chk("unexpected_start", 1, 0);
          if (to_mode && t0 < 0) t0 = cyc;
        end
        if (to_mode && t0 >= 0) chk("err_timeout", err_timeout, (cyc >= t0 + BT));
        if (msg_done) begin
          chk("msg_end", m_end, 1);
          chk("release_gv", grant_valid, 0);
          m_ovl_sticky = m_ovl_sticky | m_ovl;
          chk("err_overlength", err_overlength, m_ovl_sticky);
          m_last = m_src;
          grant_log.push_back(m_src);
          n_done++;
        end
        for (int i = 0; i < N; i++) begin
          if (stall_left[i] > 0 && stall_left[i] < 20) begin
            chk("stall_no_start", tx_start, 0);
            chk("stall_grant_held", grant_valid, 1);
          end
        end
        gv_prev = grant_valid; start_prev = tx_start; valid_prev = req_valid;
      end
    end
  end

  logic [7:0] t1_bytes [7];

  initial begin : main
    t1_bytes = '{8'h07, 8'h00, 8'h01, 8'h00, 8'h0A, 8'hFF, 8'h9C};
    reset_in = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    #3;
    chk("rst_outputs", {req_ready, tx_start, tx_data, grant_valid, grant_id, msg_done,
                        err_timeout, err_overlength}, 0);
    reset_in = 1'b0;

    // single source, literal 7-byte message
    for (int i = 0; i < 7; i++) push_byte(0, t1_bytes[i], i == 6);
    wait_done(1, 400);
    chk("t1_starts", n_start, 7);
    chk("t1_readies", n_ready[0], 7);
    chk("t1_grants", grant_log.size(), 1);
    if (grant_log.size() == 1) chk("t1_grant_id", grant_log[0], 0);
    chk("t1_sent_len", sent_log.size(), 7);
    for (int i = 0; i < 7 && i < sent_log.size(); i++) chk("t1_byte", sent_log[i], t1_bytes[i]);

    // sources 1 and 3 together
    do_reset();
    push_msg(1, 1 + $urandom_range(4), 1'b1);
    push_msg(3, 1 + $urandom_range(4), 1'b1);
    wait_done(2, 800);
    chk("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first", grant_log[0], 1);
      chk("t2_second", grant_log[1], 3);
    end

    // all four sources continuously valid
    do_reset();
    for (int s = 0; s < N; s++) begin
      push_msg(s, 2, 1'b1);
      push_msg(s, 2, 1'b1);
    end
    wait_done(8, 2500);
    chk("t3_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t3_rr_order", grant_log[i], i % 4);

    // source 2 stalls mid-message; source 0 must wait
    do_reset();
    stall_at[2] = 3;
    push_msg(2, 7, 1'b1);
    repeat (6) @(negedge clk_in);
    #3;
    push_msg(0, 2, 1'b1);
    wait_done(2, 1000);
    chk("t4_popped", popped[2], 7);
    chk("t4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t4_first", grant_log[0], 2);
      chk("t4_second", grant_log[1], 0);
    end

    // UART never goes busy
    do_reset();
    busy_en = 1'b0;
    to_mode = 1'b1;
    push_msg(1, 3, 1'b1);
    wait_done(1, 400);
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_starts", n_start, 3);
    to_mode = 1'b0;
    busy_en = 1'b1;

    // no req_last: cap at MAXB bytes
    do_reset();
    push_msg(0, MAXB, 1'b0);
    push_byte(0, 8'($urandom), 1'b1);
    push_msg(1, 2, 1'b1);
    wait_done(3, 3000);
    chk("t6_err_overlength", err_overlength, 1);
    chk("t6_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t6_g0", grant_log[0], 0);
      chk("t6_g1", grant_log[1], 1);
      chk("t6_g2", grant_log[2], 0);
    end

    // asynchronous reset in the middle of a byte
    push_msg(2, 3, 1'b1);
    begin
      int c;
      c = 0;
      while (!tx_start && c < 100) begin
        @(negedge clk_in); #3;
        c++;
      end
      chk("t7_started", tx_start, 1);
    end
    @(negedge clk_in); #3;
    chk("t7_gv_before", grant_valid, 1);
    reset_in = 1'b1;
    #1;
    chk("t7_async_rst", {req_ready, tx_start, tx_data, grant_valid, grant_id, msg_done,
                         err_timeout, err_overlength}, 0);
    model_reset();
    @(negedge clk_in); #3;
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
